// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with a two-entry skid
// buffer, synchronous flush to a bubble payload and a saturating counter of
// entries discarded by flushes. All outputs come straight from flops, so
// in_ready_o has no combinational path from out_ready_i.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
    parameter logic [31:0]       FLUSH_VAL = 32'h0000_0013,
    parameter int unsigned       CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    // Bubble payload resized to the datapath width (zero-extend or truncate).
    localparam logic [WIDTH-1:0] FLUSH_W = WIDTH'(FLUSH_VAL);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Saturating add of a 0..2 increment onto the drop counter; never wraps.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Occupancy encoding of a state; the three legal states map to 0/1/2.
    function automatic logic [1:0] occ_of(input state_t st);
        case (st)
            ST_EMPTY: return 2'd0;
            ST_ONE:   return 2'd1;
            ST_FULL:  return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] main_q,      main_d;
    logic [WIDTH-1:0] skid_q,      skid_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       occupancy_q;

    logic             push_s;
    logic             pop_s;
    logic [1:0]       drop_inc_s;

    // Handshake qualifiers use only registered flags on our side.
    assign push_s = in_valid_i & in_ready_q;
    assign pop_s  = out_valid_q & out_ready_i;

    // Entries lost by a flush: what we hold, minus what leaves, plus what
    // arrives in the same cycle. Range is 0..2 (no pop when empty, no push
    // when full).
    assign drop_inc_s = occupancy_q + {1'b0, push_s} - {1'b0, pop_s};

    // Next-state and datapath selection; flush overrides every transfer.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            state_d    = ST_EMPTY;
            main_d     = FLUSH_W;
            skid_d     = FLUSH_W;
            drop_cnt_d = sat_add(drop_cnt_q, drop_inc_s);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end else if (push_s) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end else if (pop_s) begin
                        main_d  = FLUSH_W;
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop_s) begin
                        main_d  = skid_q;
                        skid_d  = FLUSH_W;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean bubble.
                    main_d  = FLUSH_W;
                    skid_d  = FLUSH_W;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, payload, counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            drop_cnt_q  <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            drop_cnt_q  <= drop_cnt_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            occupancy_q <= occ_of(state_d);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = occupancy_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
